cla_word_serial_add_ctrl: RTL and testbench

//  Sequencer that drives one external WORD_W-bit carry-lookahead adder slice over NUM_WORDS cycles.

---
 rtl/cla_word_serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_cla_word_serial_add_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_serial_add_ctrl.sv
// Word-serial sequencer for an external combinational CLA slice: one word per cycle, result after NUM_WORDS+1 clocks.
// Single request in flight; in_ready only in IDLE, the result is held in DONE until out_ready.
module cla_word_serial_add_ctrl #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 4,
  localparam int N        = WORD_W * NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_a,
  input  logic [N-1:0]      in_b,
  input  logic              in_cin,
  input  logic              in_sub,
  output logic [WORD_W-1:0] cla_a,
  output logic [WORD_W-1:0] cla_b,
  output logic              cla_cin,
  input  logic [WORD_W-1:0] cla_sum,
  input  logic              cla_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_sum,
  output logic              out_cout,
  output logic              out_ovf
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                           state, state_nxt;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_WORDS-1:0][WORD_W-1:0] a_q, b_q, acc_q, acc_nxt, sum_q;
  logic                             carry_q, cout_q, ovf_q;
  logic                             accept, last_word;

  assign accept    = in_valid && (state == IDLE);
  assign last_word = (state == RUN) && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice inputs come straight from registers so the slice never sees glitches.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cla_a     = '0;
    cla_b     = '0;
    cla_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        cla_a   = a_q[idx];
        cla_b   = b_q[idx];
        cla_cin = carry_q;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_nxt      = acc_q;
    acc_nxt[idx] = cla_sum;
  end

  // Result registers load only on the last word, so they stay put through the next request's RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? 1'b1 : in_cin;
    end else if (state == RUN) begin
      idx     <= idx + 1'b1;
      acc_q   <= acc_nxt;
      carry_q <= cla_cout;
      if (last_word) begin
        sum_q  <= acc_nxt;
        cout_q <= cla_cout;
        ovf_q  <= a_q[NUM_WORDS-1][WORD_W-1] ^ b_q[NUM_WORDS-1][WORD_W-1]
                ^ acc_nxt[NUM_WORDS-1][WORD_W-1] ^ cla_cout;
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_cla_word_serial_add_ctrl.sv
// Bench for cla_word_serial_add_ctrl: 4-word and 1-word instances, each driving a behavioural 8-bit CLA slice.
module tb_cla_word_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // 4-word instance
  logic        in_valid = 0, in_ready, in_cin = 0, in_sub = 0;
  logic [31:0] in_a = 0, in_b = 0, out_sum;
  logic [7:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout, out_valid, out_ready = 0, out_cout, out_ovf;

  // 1-word instance
  logic        in_valid1 = 0, in_ready1, in_cin1 = 0, in_sub1 = 0;
  logic [7:0]  in_a1 = 0, in_b1 = 0, out_sum1;
  logic [7:0]  cla_a1, cla_b1, cla_sum1;
  logic        cla_cin1, cla_cout1, out_valid1, out_ready1 = 0, out_cout1, out_ovf1;

  cla_word_serial_add_ctrl #(.WORD_W(8), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  cla_word_serial_add_ctrl #(.WORD_W(8), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_sub(in_sub1),
    .cla_a(cla_a1), .cla_b(cla_b1), .cla_cin(cla_cin1), .cla_sum(cla_sum1), .cla_cout(cla_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  // Behavioural CLA slices: generate/propagate with a lookahead carry chain
  logic [8:0] cc, cc1;
  always_comb begin
    cc    = '0;
    cc[0] = cla_cin;
    for (int i = 0; i < 8; i++) cc[i+1] = (cla_a[i] & cla_b[i]) | ((cla_a[i] ^ cla_b[i]) & cc[i]);
    cla_sum  = cla_a ^ cla_b ^ cc[7:0];
    cla_cout = cc[8];
  end
  always_comb begin
    cc1    = '0;
    cc1[0] = cla_cin1;
    for (int i = 0; i < 8; i++) cc1[i+1] = (cla_a1[i] & cla_b1[i]) | ((cla_a1[i] ^ cla_b1[i]) & cc1[i]);
    cla_sum1  = cla_a1 ^ cla_b1 ^ cc1[7:0];
    cla_cout1 = cc1[8];
  end

  // Issue one request on the 4-word DUT and collect its result; entered and left at #1 after an edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input bit rand_rdy, output logic [31:0] s, output logic co, output logic ov,
                        output int lat, output bit ok);
    int n = 0;
    ok = 0; lat = 0; s = '0; co = 0; ov = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin in_valid = 0; return; end
    @(posedge clk); #1;
    in_valid = 0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
    for (int i = 1; i <= 60; i++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (out_valid && lat == 0) lat = i;
      if (out_valid && out_ready) begin
        s = out_sum; co = out_cout; ov = out_ovf; ok = 1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                         input bit rand_rdy, output logic [7:0] s, output logic co, output logic ov,
                         output int lat, output bit ok);
    int n = 0;
    ok = 0; lat = 0; s = '0; co = 0; ov = 0;
    in_a1 = a; in_b1 = b; in_cin1 = cin; in_sub1 = sub; in_valid1 = 1;
    while (!in_ready1 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready1) begin in_valid1 = 0; return; end
    @(posedge clk); #1;
    in_valid1 = 0; in_a1 = 8'($urandom); in_b1 = 8'($urandom);
    for (int i = 1; i <= 60; i++) begin
      if (rand_rdy) out_ready1 = 1'($urandom_range(0, 1));
      if (out_valid1 && lat == 0) lat = i;
      if (out_valid1 && out_ready1) begin
        s = out_sum1; co = out_cout1; ov = out_ovf1; ok = 1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h co=%b ov=%b, required 1 0 00000000 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end else pass_cnt++;
    total_cnt++;
    if ({cla_a, cla_b, cla_cin} !== 17'h0) $display("FAIL reset_cla: a=%h b=%h cin=%b, required 0", cla_a, cla_b, cla_cin);
    else pass_cnt++;
    #5 rst = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic cin, sub;
    logic [31:0] s;
    logic co, ov;
  } vec_t;

  task automatic test_add_sub();
    vec_t v[4];
    logic [31:0] s; logic co, ov; int lat; bit ok;
    v[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    v[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    v[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    v[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, 0, s, co, ov, lat, ok);
      total_cnt++;
      if (!ok) $display("FAIL vec%0d_timeout: no result handshake, required one", i);
      else pass_cnt++;
      total_cnt++;
      if (s !== v[i].s) $display("FAIL vec%0d_sum: got %h, required %h", i, s, v[i].s);
      else pass_cnt++;
      total_cnt++;
      if ({co, ov} !== {v[i].co, v[i].ov}) $display("FAIL vec%0d_flags: cout/ovf got %b%b, required %b%b", i, co, ov, v[i].co, v[i].ov);
      else pass_cnt++;
      total_cnt++;
      if (lat != 5) $display("FAIL vec%0d_latency: got %0d, required 5", i, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit stable_ok = 1;
    out_ready = 0;
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 0; in_sub = 0; in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // second request held pending for the whole busy period
    in_a = 32'h0000_0003; in_b = 32'h0000_0001; in_sub = 1;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_sum === 32'h2345_6789 &&
            out_cout === 1'b0 && out_ovf === 1'b0)) stable_ok = 0;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!stable_ok) $display("FAIL bp_hold: vld=%b rdy=%b sum=%h, required 1 0 23456789 held 3 cycles", out_valid, in_ready, out_sum);
    else pass_cnt++;
    out_ready = 1;
    @(posedge clk); #1;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release: rdy/vld got %b%b, required 10", in_ready, out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 32'h0000_0002, 1'b1, 1'b0})
      $display("FAIL bp_next: vld=%b sum=%h co=%b ov=%b, required 1 00000002 1 0", out_valid, out_sum, out_cout, out_ovf);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0, n = 0;
    logic [31:0] s; logic co, ov; int lat; bit ok;
    out_ready = 1;
    in_a = 32'h0F0F_0F0F; in_b = 32'h0101_0101; in_cin = 0; in_sub = 0; in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_sum, cla_a} !== {1'b1, 1'b0, 32'h0, 8'h0})
      $display("FAIL rst_mid_run: rdy=%b vld=%b sum=%h cla_a=%h, required 1 0 0 0", in_ready, out_valid, out_sum, cla_a);
    else pass_cnt++;
    #1 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL rst_no_valid: out_valid seen %0d cycles, required 0", seen);
    else pass_cnt++;
    run_op(32'd1, 32'd1, 0, 0, 0, s, co, ov, lat, ok);
    total_cnt++;
    if (!ok || s !== 32'd2 || co !== 1'b0) $display("FAIL rst_then_add: ok=%b sum=%h co=%b, required 1 00000002 0", ok, s, co);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs = 0;
    logic [31:0] a, b, beff, s, es; logic cin, sub, co, ov, eco, eov; int lat; bit ok;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      if (i % 7 == 0) b = 32'hFFFF_FFFF;
      beff = sub ? ~b : b;
      {eco, es} = {1'b0, a} + {1'b0, beff} + 33'(sub ? 1'b1 : cin);
      eov = (a[31] == beff[31]) && (es[31] != a[31]);
      run_op(a, b, cin, sub, 1, s, co, ov, lat, ok);
      total_cnt++;
      if (!ok || {s, co, ov} !== {es, eco, eov}) begin
        if (errs < 10) $display("FAIL rand4_op%0d: ok=%b sum=%h co=%b ov=%b, required %h %b %b", i, ok, s, co, ov, es, eco, eov);
        errs++;
      end else pass_cnt++;
    end
    out_ready = 1;
  endtask

  task automatic test_single_word();
    int errs = 0;
    logic [7:0] a, b, beff, s, es; logic cin, sub, co, ov, eco, eov; int lat; bit ok;
    out_ready1 = 1;
    run_op1(8'hFF, 8'h01, 0, 0, 0, s, co, ov, lat, ok);
    total_cnt++;
    if (!ok || {s, co, ov} !== {8'h00, 1'b1, 1'b0} || lat != 2)
      $display("FAIL w1_wrap: ok=%b sum=%h co=%b ov=%b lat=%0d, required 00 1 0 lat 2", ok, s, co, ov, lat);
    else pass_cnt++;
    run_op1(8'h7F, 8'h01, 0, 0, 0, s, co, ov, lat, ok);
    total_cnt++;
    if (!ok || {s, co, ov} !== {8'h80, 1'b0, 1'b1}) $display("FAIL w1_ovf: sum=%h co=%b ov=%b, required 80 0 1", s, co, ov);
    else pass_cnt++;
    run_op1(8'h05, 8'h07, 0, 1, 0, s, co, ov, lat, ok);
    total_cnt++;
    if (!ok || {s, co, ov} !== {8'hFE, 1'b0, 1'b0}) $display("FAIL w1_sub: sum=%h co=%b ov=%b, required FE 0 0", s, co, ov);
    else pass_cnt++;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      beff = sub ? ~b : b;
      {eco, es} = {1'b0, a} + {1'b0, beff} + 9'(sub ? 1'b1 : cin);
      eov = (a[7] == beff[7]) && (es[7] != a[7]);
      run_op1(a, b, cin, sub, 1, s, co, ov, lat, ok);
      total_cnt++;
      if (!ok || {s, co, ov} !== {es, eco, eov}) begin
        if (errs < 10) $display("FAIL rand1_op%0d: ok=%b sum=%h co=%b ov=%b, required %h %b %b", i, ok, s, co, ov, es, eco, eov);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_single_word();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
